// File: rtl/ram_serial_loader.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | ram_serial_loader: 8N1 UART receiver feeding sequential 16x8 RAM writes.  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module ram_serial_loader #(
  parameter int CLKS_PER_BIT = 16,
  parameter int ADDR_W       = 4,
  parameter int DATA_W       = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_i,
  input  logic              start_i,
  output logic              prog_mode,
  output logic [ADDR_W-1:0] prog_addr,
  output logic [DATA_W-1:0] w_data,
  output logic              busy_o,
  output logic              done_o,
  output logic              frame_err_o
);

  localparam int c_CNT_W = $clog2(CLKS_PER_BIT);
  localparam int c_IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  localparam logic [c_CNT_W-1:0] c_HALF_LAST = c_CNT_W'(CLKS_PER_BIT/2 - 1);
  localparam logic [c_CNT_W-1:0] c_FULL_LAST = c_CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [c_IDX_W-1:0] c_IDX_LAST  = c_IDX_W'(DATA_W - 1);
  localparam logic [ADDR_W-1:0]  c_LAST_ADDR = {ADDR_W{1'b1}};

  localparam logic [1:0] c_S_IDLE  = 2'd0;
  localparam logic [1:0] c_S_START = 2'd1;
  localparam logic [1:0] c_S_DATA  = 2'd2;
  localparam logic [1:0] c_S_STOP  = 2'd3;

  logic              r_rx_meta;
  logic              r_rx_sync;
  logic              r_rx_prev;
  logic [1:0]        r_state;
  logic [c_CNT_W-1:0] r_cnt;
  logic [c_IDX_W-1:0] r_idx;
  logic [DATA_W-1:0] r_shift;
  logic              r_rx_valid;
  logic              r_rx_ferr;
  logic [ADDR_W-1:0] r_addr;

  logic              w_accept;
  logic [ADDR_W-1:0] w_load_base;

  // Synchroniser presets high so reset never looks like a start bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rx_meta <= 1'b1;
      r_rx_sync <= 1'b1;
      r_rx_prev <= 1'b1;
    end else begin
      r_rx_meta <= rx_i;
      r_rx_sync <= r_rx_meta;
      r_rx_prev <= r_rx_sync;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= c_S_IDLE;
      r_cnt      <= '0;
      r_idx      <= '0;
      r_shift    <= '0;
      r_rx_valid <= 1'b0;
      r_rx_ferr  <= 1'b0;
    end else begin
      r_rx_valid <= 1'b0;
      r_rx_ferr  <= 1'b0;
      case (r_state)
        c_S_IDLE: begin
          // Edge-triggered, so a held-low break cannot retrigger a frame.
          if (r_rx_prev && !r_rx_sync) begin
            r_state <= c_S_START;
            r_cnt   <= '0;
          end
        end
        c_S_START: begin
          if (r_cnt == c_HALF_LAST) begin
            r_cnt <= '0;
            r_idx <= '0;
            r_state <= r_rx_sync ? c_S_IDLE : c_S_DATA;
          end else begin
            r_cnt <= r_cnt + c_CNT_W'(1);
          end
        end
        c_S_DATA: begin
          if (r_cnt == c_FULL_LAST) begin
            r_cnt   <= '0;
            r_shift <= {r_rx_sync, r_shift[DATA_W-1:1]};
            if (r_idx == c_IDX_LAST) begin
              r_state <= c_S_STOP;
            end else begin
              r_idx <= r_idx + c_IDX_W'(1);
            end
          end else begin
            r_cnt <= r_cnt + c_CNT_W'(1);
          end
        end
        c_S_STOP: begin
          if (r_cnt == c_FULL_LAST) begin
            r_cnt      <= '0;
            r_rx_valid <= r_rx_sync;
            r_rx_ferr  <= !r_rx_sync;
            r_state    <= c_S_IDLE;
          end else begin
            r_cnt <= r_cnt + c_CNT_W'(1);
          end
        end
        default: r_state <= c_S_IDLE;
      endcase
    end
  end

  // A byte landing with start_i is taken as the first byte of the new load.
  assign w_accept    = r_rx_valid && (busy_o || start_i);
  assign w_load_base = start_i ? '0 : r_addr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prog_mode   <= 1'b0;
      prog_addr   <= '0;
      w_data      <= '0;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
      frame_err_o <= 1'b0;
      r_addr      <= '0;
    end else begin
      prog_mode <= 1'b0;
      done_o    <= 1'b0;
      if (r_rx_ferr) begin
        frame_err_o <= 1'b1;
      end
      if (prog_mode && (prog_addr == c_LAST_ADDR) && !start_i) begin
        done_o <= 1'b1;
        busy_o <= 1'b0;
      end
      if (start_i) begin
        busy_o      <= 1'b1;
        r_addr      <= '0;
        frame_err_o <= 1'b0;
      end
      if (w_accept) begin
        prog_mode <= 1'b1;
        prog_addr <= w_load_base;
        w_data    <= r_shift;
        r_addr    <= w_load_base + ADDR_W'(1);
      end
    end
  end

endmodule
`default_nettype wire
